// File: rtl/int_wb_arbiter.sv
// int_wb_arbiter: round-robin/starvation arbiter sharing NUM_PORT int writeback ports among NUM_REQ FU results
module int_wb_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_PORT   = 2,
   parameter int ROBIDX_W   = 6,
   parameter int IROBIDX_W  = 4,
   parameter int IPRIDX_W   = 7,
   parameter int XLEN       = 64,
   parameter int STARVE_LIM = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_flush,
   input  logic [NUM_REQ-1:0]            i_req_vld,
   output logic [NUM_REQ-1:0]            o_req_rdy,
   input  logic [NUM_REQ*ROBIDX_W-1:0]   i_req_rob_idx,
   input  logic [NUM_REQ*IROBIDX_W-1:0]  i_req_irob_idx,
   input  logic [NUM_REQ-1:0]            i_req_rd_wen,
   input  logic [NUM_REQ*IPRIDX_W-1:0]   i_req_iprd_idx,
   input  logic [NUM_REQ*XLEN-1:0]       i_req_result,
   output logic [NUM_PORT-1:0]           o_wb_vld,
   output logic [NUM_PORT*ROBIDX_W-1:0]  o_wb_rob_idx,
   output logic [NUM_PORT*IROBIDX_W-1:0] o_wb_irob_idx,
   output logic [NUM_PORT-1:0]           o_wb_rd_wen,
   output logic [NUM_PORT*IPRIDX_W-1:0]  o_wb_iprd_idx,
   output logic [NUM_PORT*XLEN-1:0]      o_wb_result,
   output logic [NUM_PORT*3-1:0]         o_wb_src
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]                 r_rr_ptr;
   logic [3:0]                    r_starve [NUM_REQ];
   logic [NUM_PORT-1:0]           r_wb_vld;
   logic [NUM_PORT*ROBIDX_W-1:0]  r_wb_rob;
   logic [NUM_PORT*IROBIDX_W-1:0] r_wb_irob;
   logic [NUM_PORT-1:0]           r_wb_wen;
   logic [NUM_PORT*IPRIDX_W-1:0]  r_wb_iprd;
   logic [NUM_PORT*XLEN-1:0]      r_wb_res;
   logic [NUM_PORT*3-1:0]         r_wb_src;

   logic [NUM_REQ-1:0]  w_rdy;
   logic [NUM_PORT-1:0] w_gvld;
   logic [2:0]          w_gidx [NUM_PORT];
   logic                w_p2;
   logic [PW-1:0]       w_last;
   logic                w_en;
   int                  w_n;

   assign w_en      = rst && !i_flush;
   assign o_req_rdy = w_rdy;

   // Two-pass grant: saturated-starve requesters by ascending index, then round-robin from rr_ptr; k-th grant drives port k
   always_comb begin
      w_rdy  = '0;
      w_gvld = '0;
      w_gidx = '{default: '0};
      w_p2   = 1'b0;
      w_last = '0;
      w_n    = 0;
      for (int r = 0; r < NUM_REQ; r++)
         if (w_en && i_req_vld[r] && r_starve[r] == 4'(STARVE_LIM) && w_n < NUM_PORT) begin
            for (int k = 0; k < NUM_PORT; k++)
               if (w_n == k) begin
                  w_gidx[k] = 3'(r);
                  w_gvld[k] = 1'b1;
               end
            w_rdy[r] = 1'b1;
            w_n++;
         end
      for (int o = 0; o < NUM_REQ; o++)
         for (int r = 0; r < NUM_REQ; r++)
            if (r == (int'(r_rr_ptr) + o) % NUM_REQ && w_en && i_req_vld[r] && !w_rdy[r] && w_n < NUM_PORT) begin
               for (int k = 0; k < NUM_PORT; k++)
                  if (w_n == k) begin
                     w_gidx[k] = 3'(r);
                     w_gvld[k] = 1'b1;
                  end
               w_rdy[r] = 1'b1;
               w_p2     = 1'b1;
               w_last   = PW'((r + 1) % NUM_REQ);
               w_n++;
            end
   end

   // Arbiter state: rotate pointer past last round-robin winner, age denied requesters, clear everything on flush
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_rr_ptr <= '0;
         for (int r = 0; r < NUM_REQ; r++) r_starve[r] <= '0;
      end else if (i_flush) begin
         r_rr_ptr <= '0;
         for (int r = 0; r < NUM_REQ; r++) r_starve[r] <= '0;
      end else begin
         if (w_p2) r_rr_ptr <= w_last;
         for (int r = 0; r < NUM_REQ; r++)
            r_starve[r] <= (!i_req_vld[r] || w_rdy[r]) ? 4'd0 :
                           (r_starve[r] == 4'(STARVE_LIM)) ? r_starve[r] : r_starve[r] + 4'd1;
      end

   // Writeback ports: register the granted payload; ports without a grant go invalid and hold their payload
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_wb_vld  <= '0;
         r_wb_rob  <= '0;
         r_wb_irob <= '0;
         r_wb_wen  <= '0;
         r_wb_iprd <= '0;
         r_wb_res  <= '0;
         r_wb_src  <= '0;
      end else begin
         r_wb_vld <= w_gvld;
         for (int k = 0; k < NUM_PORT; k++)
            for (int r = 0; r < NUM_REQ; r++)
               if (w_gvld[k] && w_gidx[k] == 3'(r)) begin
                  r_wb_rob[k*ROBIDX_W +: ROBIDX_W]   <= i_req_rob_idx[r*ROBIDX_W +: ROBIDX_W];
                  r_wb_irob[k*IROBIDX_W +: IROBIDX_W] <= i_req_irob_idx[r*IROBIDX_W +: IROBIDX_W];
                  r_wb_wen[k]                        <= i_req_rd_wen[r];
                  r_wb_iprd[k*IPRIDX_W +: IPRIDX_W]   <= i_req_iprd_idx[r*IPRIDX_W +: IPRIDX_W];
                  r_wb_res[k*XLEN +: XLEN]           <= i_req_result[r*XLEN +: XLEN];
                  r_wb_src[k*3 +: 3]                 <= 3'(r);
               end
      end

   assign o_wb_vld      = r_wb_vld;
   assign o_wb_rob_idx  = r_wb_rob;
   assign o_wb_irob_idx = r_wb_irob;
   assign o_wb_rd_wen   = r_wb_wen;
   assign o_wb_iprd_idx = r_wb_iprd;
   assign o_wb_result   = r_wb_res;
   assign o_wb_src      = r_wb_src;
endmodule
